bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter in front of the Bridge data bus. Master 0 is the CPU load/store port; master 1 is a secondary master such as the program loader or a DMA engine.
- Latches one request at a time and drives Bus_addr/Bus_we/Bus_wdata for a fixed access window. Returns read data with a one-cycle ack pulse.
- Priority is round-robin, with an optional bounded lock so a master can complete short back-to-back sequences.

Parameters:
- WAIT_CYC, 0, extra bus cycles held after the address cycle before read data is sampled (0..15).
- MAX_LOCK, 4, max consecutive locked transactions one master may win while the other is requesting (1..15).

Ports:
- cpu_clk  input  1  clock; all state changes on the rising edge.
- cpu_rst_n  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held with addr/we/wdata until m0_ack.
- m0_we  input  1  master 0 write enable (1 = write).
- m0_addr  input  32  master 0 byte address.
- m0_wdata  input  32  master 0 write data.
- m0_lock  input  1  master 0 asks to keep the grant for its next request.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m0_rdata  output  32  read data for master 0; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_ack, m1_rdata: same as master 0, for master 1.
- Bus_addr  output  32  address to the Bridge.
- Bus_we  output  1  write strobe to the Bridge.
- Bus_wdata  output  32  write data to the Bridge.
- Bus_rdata  input  32  read data from the Bridge (combinational).
- grant  output  2  one-hot owner of the current transaction; 2'b00 when idle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (cpu_rst_n=0, asynchronous):
  - State goes to IDLE.
  - grant=0, busy=0, both acks=0, both rdata=0.
  - Bus_addr, Bus_we and Bus_wdata are 0.
  - last_grant is set to M1, so M0 wins the first tie.
  - lock_cnt=0.
- FSM has four states: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - If any req=1, pick a winner and latch its we/addr/wdata and its index. Next state is ADDR.
  - Otherwise stay in IDLE.
- Winner selection:
  - Only one requester: it wins.
  - Both requesting: the master that is not last_grant wins.
  - Lock exception: if the previous owner finished with lock=1 and lock_cnt<MAX_LOCK, the previous owner wins again and lock_cnt increments.
  - A lock win is taken only while the locking master is requesting.
  - lock_cnt clears whenever ownership changes or the owner finished with lock=0.
  - A lone requester always wins and does not touch lock_cnt.
- ADDR (1 cycle):
  - Bus_addr, Bus_wdata and Bus_we are driven from the latched values; Bus_we=1 only for a write.
  - If WAIT_CYC=0, sample Bus_rdata into rdata_q at the end of this cycle and go to RESP.
  - Otherwise go to WAIT.
- WAIT (WAIT_CYC cycles):
  - Bus_addr and Bus_wdata stay stable; Bus_we=0, so the write strobe lasts exactly one cycle.
  - Bus_rdata is sampled on the last WAIT cycle, then next state is RESP.
- RESP (1 cycle):
  - The owner's ack=1 and its rdata=rdata_q. The other master's ack=0 and its rdata=0.
  - For writes, rdata is don't-care and is driven with rdata_q.
  - Bus_* outputs are 0.
  - last_grant is updated to the owner.
  - Next state is IDLE.
- Outside ADDR/WAIT, all Bus_* outputs are 0. grant is one-hot in ADDR, WAIT and RESP.
- Latency: req seen in IDLE at cycle t gives ack at t+2+WAIT_CYC. One transaction takes 3+WAIT_CYC cycles.
- A master dropping req mid-transaction does not abort it; the transaction completes and ack still pulses.
- A master keeping req=1 after its ack is treated as a new request in IDLE.
- Requests arriving during busy are not latched until IDLE.
- Reset asserted mid-transaction abandons the transaction: no ack is issued and Bus_we drops to 0 immediately (asynchronous).

Optional Feature:
- Macro: BUS_ARB_PERF_EN.
- When defined:
  - Two extra output ports, m0_grant_cnt[31:0] and m1_grant_cnt[31:0].
  - Each counter increments on every RESP cycle owned by that master.
  - Counters wrap 32'hFFFFFFFF to 0 and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then m0 read at addr 0x8010_0000 with Bus_rdata=0xDEAD_BEEF and WAIT_CYC=0:
  - Bus_addr=0x8010_0000 and Bus_we=0 for exactly 1 cycle.
  - m0_ack pulses 2 cycles after req with m0_rdata=0xDEAD_BEEF; grant=2'b01.
- m1 write of 0x1234_5678 to 0x8020_0000 with WAIT_CYC=2:
  - Bus_we=1 for exactly 1 cycle; Bus_addr/Bus_wdata are held for 3 cycles.
  - m1_ack arrives at t+4; m0_ack stays 0.
- Both masters requesting continuously with lock=0: grants alternate M0, M1, M0, M1 starting with M0 after reset. Each ack arrives 3 cycles after the previous one.
- Both requesting, m1 with lock=1 after winning once, MAX_LOCK=4:
  - m1 wins 5 consecutive transactions (the initial win plus 4 locked), then M0 is granted.
  - lock_cnt returns to 0.
- Assert cpu_rst_n=0 during WAIT of an m0 write:
  - Bus_* go to 0 asynchronously and no ack is issued.
  - After release, an m1 request is served first only if m0 is not requesting; otherwise M0 wins.
- With BUS_ARB_PERF_EN, 3 m0 and 2 m1 transactions: m0_grant_cnt=3 and m1_grant_cnt=2. Both counters reset to 0 on cpu_rst_n.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with bounded lock in front of the Bridge bus.
// Define BUS_ARB_PERF_EN to add per-master grant counters.
module bus_arbiter #(
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] Bus_addr,
    output logic        Bus_we,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata,
    output logic [1:0]  grant,
`ifdef BUS_ARB_PERF_EN
    output logic [31:0] m0_grant_cnt,
    output logic [31:0] m1_grant_cnt,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_e;

    localparam int unsigned WLAST     = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam logic [3:0]  WAIT_LAST = WLAST[3:0];
    localparam logic [3:0]  LOCK_MAX  = MAX_LOCK[3:0];

    state_e      state_q;
    logic        own_q;
    logic [3:0]  wcnt_q;
    logic        last_q;
    logic        lock_pend_q;
    logic [3:0]  lock_cnt_q;
    logic [31:0] rdata_q;

    logic        both;
    logic        lock_win;
    logic        own_d;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        own_lock;
    logic        sample;

    always_comb begin
        both     = m0_req & m1_req;
        lock_win = both & lock_pend_q & (lock_cnt_q < LOCK_MAX);
        own_d    = m1_req;
        if (both) begin
            own_d = lock_win ? last_q : ~last_q;
        end
        win_we    = own_d ? m1_we    : m0_we;
        win_addr  = own_d ? m1_addr  : m0_addr;
        win_wdata = own_d ? m1_wdata : m0_wdata;
        own_lock  = own_q ? m1_lock  : m0_lock;
        sample    = ((state_q == ADDR) && (WAIT_CYC == 0)) ||
                    ((state_q == WAIT) && (wcnt_q == '0));
    end

    // Read data is only presented to the master being acknowledged.
    assign m0_rdata = m0_ack ? rdata_q : '0;
    assign m1_rdata = m1_ack ? rdata_q : '0;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= IDLE;
            own_q       <= 1'b0;
            wcnt_q      <= '0;
            last_q      <= 1'b1;
            lock_pend_q <= 1'b0;
            lock_cnt_q  <= '0;
            rdata_q     <= '0;
            Bus_addr    <= '0;
            Bus_we      <= 1'b0;
            Bus_wdata   <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
`ifdef BUS_ARB_PERF_EN
            m0_grant_cnt <= '0;
            m1_grant_cnt <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        state_q   <= ADDR;
                        own_q     <= own_d;
                        Bus_addr  <= win_addr;
                        Bus_we    <= win_we;
                        Bus_wdata <= win_wdata;
                        grant     <= own_d ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        if (both) begin
                            lock_cnt_q <= lock_win ? lock_cnt_q + 4'd1 : '0;
                        end
                    end
                end
                ADDR: begin
                    Bus_we  <= 1'b0;
                    wcnt_q  <= WAIT_LAST;
                    state_q <= sample ? RESP : WAIT;
                end
                WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (sample) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    grant       <= '0;
                    busy        <= 1'b0;
                    m0_ack      <= 1'b0;
                    m1_ack      <= 1'b0;
                    last_q      <= own_q;
                    lock_pend_q <= own_lock;
                    if (!own_lock) begin
                        lock_cnt_q <= '0;
                    end
`ifdef BUS_ARB_PERF_EN
                    if (own_q) begin
                        m1_grant_cnt <= m1_grant_cnt + 32'd1;
                    end else begin
                        m0_grant_cnt <= m0_grant_cnt + 32'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
            // Last bus cycle: capture read data, release the bus, raise ack.
            if (sample) begin
                rdata_q   <= Bus_rdata;
                Bus_addr  <= '0;
                Bus_we    <= 1'b0;
                Bus_wdata <= '0;
                m0_ack    <= ~own_q;
                m1_ack    <= own_q;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter
// against a transaction-level arbitration model.
module tb_bus_arbiter;

    localparam int W  = 2;
    localparam int ML = 4;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        m0_req, m0_we, m0_lock, m0_ack;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_ack;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
    logic        Bus_we;
    logic [1:0]  grant;
    logic        busy;
`ifdef BUS_ARB_PERF_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt;
`endif

    logic        rd_fix_en;
    logic [31:0] rd_fix;

    int n_pass;
    int n_tot;
    int ack_own [32];
    int ack_cyc [32];
    int ack_n;
    int ack_both;

    assign Bus_rdata = rd_fix_en ? rd_fix : (Bus_addr ^ 32'h5A5A_A5A5);

    bus_arbiter #(
        .WAIT_CYC(W),
        .MAX_LOCK(ML)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .Bus_addr  (Bus_addr),
        .Bus_we    (Bus_we),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .grant     (grant),
`ifdef BUS_ARB_PERF_EN
        .m0_grant_cnt (m0_grant_cnt),
        .m1_grant_cnt (m1_grant_cnt),
`endif
        .busy      (busy)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic set_m(input int m, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic lk);
        if (m == 0) begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = wd; m0_lock = lk;
        end else begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = wd; m1_lock = lk;
        end
    endtask

    task automatic do_reset();
        cpu_rst_n = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_m(1, 1'b0, 1'b0, '0, '0, 1'b0);
        rd_fix_en = 1'b0;
        rd_fix    = '0;
        repeat (2) @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;
    endtask

    task automatic drive_one(input int m, input logic we,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int ack_at, output int a_cyc,
                             output int we_cyc, output int wd_cyc,
                             output logic [31:0] rd, output logic [1:0] gr,
                             output int oth);
        ack_at = -1; a_cyc = 0; we_cyc = 0; wd_cyc = 0;
        rd = '0; gr = '0; oth = 0;
        set_m(m, 1'b1, we, a, wd, 1'b0);
        for (int c = 0; c < 12 + W; c++) begin
            @(negedge cpu_clk);
            if (Bus_addr == a) a_cyc++;
            if (Bus_we === 1'b1) we_cyc++;
            if (Bus_wdata == wd) wd_cyc++;
            if (((m == 0) ? m0_ack : m1_ack) === 1'b1 && ack_at < 0) begin
                ack_at = c;
                rd = (m == 0) ? m0_rdata : m1_rdata;
                gr = grant;
            end
            if (((m == 0) ? m1_ack : m0_ack) === 1'b1) oth++;
            @(posedge cpu_clk);
            #1;
            if (ack_at >= 0) set_m(m, 1'b0, 1'b0, '0, '0, 1'b0);
        end
    endtask

    task automatic collect_acks(input int n, input int budget);
        ack_n = 0;
        ack_both = 0;
        for (int i = 0; i < 32; i++) begin
            ack_own[i] = -1;
            ack_cyc[i] = -1;
        end
        for (int c = 0; c < budget && ack_n < n; c++) begin
            @(negedge cpu_clk);
            if (m0_ack === 1'b1 && m1_ack === 1'b1) ack_both++;
            if ((m0_ack === 1'b1 || m1_ack === 1'b1) && ack_n < 32) begin
                ack_own[ack_n] = (m1_ack === 1'b1) ? 1 : 0;
                ack_cyc[ack_n] = c;
                ack_n++;
            end
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_m(1, 1'b0, 1'b0, '0, '0, 1'b0);
        rd_fix_en = 1'b0;
        rd_fix    = '0;
        @(negedge cpu_clk);
        n_tot++;
        if ({grant, busy} !== 3'b000)
            $display("FAIL rst_grant_busy: got %b want 000", {grant, busy});
        else n_pass++;
        n_tot++;
        if ({m0_ack, m1_ack} !== 2'b00)
            $display("FAIL rst_acks: got %b want 00", {m0_ack, m1_ack});
        else n_pass++;
        n_tot++;
        if ({m0_rdata, m1_rdata} !== 64'h0)
            $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata});
        else n_pass++;
        n_tot++;
        if ({Bus_addr, Bus_we, Bus_wdata} !== 65'h0)
            $display("FAIL rst_bus: got %h want 0", {Bus_addr, Bus_we, Bus_wdata});
        else n_pass++;
`ifdef BUS_ARB_PERF_EN
        n_tot++;
        if ({m0_grant_cnt, m1_grant_cnt} !== 64'h0)
            $display("FAIL rst_perf: got %h want 0", {m0_grant_cnt, m1_grant_cnt});
        else n_pass++;
`endif
    endtask

    task automatic test_m0_read();
        int ack_at, a_cyc, we_cyc, wd_cyc, oth;
        logic [31:0] rd;
        logic [1:0]  gr;
        do_reset();
        rd_fix_en = 1'b1;
        rd_fix    = 32'hDEAD_BEEF;
        drive_one(0, 1'b0, 32'h8010_0000, 32'h0BAD_0001,
                  ack_at, a_cyc, we_cyc, wd_cyc, rd, gr, oth);
        n_tot++;
        if (ack_at !== 2 + W) $display("FAIL rd_ack_lat: got %0d want %0d", ack_at, 2 + W);
        else n_pass++;
        n_tot++;
        if (a_cyc !== 1 + W) $display("FAIL rd_addr_cyc: got %0d want %0d", a_cyc, 1 + W);
        else n_pass++;
        n_tot++;
        if (we_cyc !== 0) $display("FAIL rd_we_cyc: got %0d want 0", we_cyc);
        else n_pass++;
        n_tot++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", rd);
        else n_pass++;
        n_tot++;
        if (gr !== 2'b01) $display("FAIL rd_grant: got %b want 01", gr);
        else n_pass++;
        n_tot++;
        if (oth !== 0) $display("FAIL rd_other_ack: got %0d want 0", oth);
        else n_pass++;
    endtask

    task automatic test_m1_write();
        int ack_at, a_cyc, we_cyc, wd_cyc, oth;
        logic [31:0] rd;
        logic [1:0]  gr;
        do_reset();
        drive_one(1, 1'b1, 32'h8020_0000, 32'h1234_5678,
                  ack_at, a_cyc, we_cyc, wd_cyc, rd, gr, oth);
        n_tot++;
        if (ack_at !== 2 + W) $display("FAIL wr_ack_lat: got %0d want %0d", ack_at, 2 + W);
        else n_pass++;
        n_tot++;
        if (we_cyc !== 1) $display("FAIL wr_we_cyc: got %0d want 1", we_cyc);
        else n_pass++;
        n_tot++;
        if (a_cyc !== 1 + W) $display("FAIL wr_addr_cyc: got %0d want %0d", a_cyc, 1 + W);
        else n_pass++;
        n_tot++;
        if (wd_cyc !== 1 + W) $display("FAIL wr_wdata_cyc: got %0d want %0d", wd_cyc, 1 + W);
        else n_pass++;
        n_tot++;
        if (gr !== 2'b10) $display("FAIL wr_grant: got %b want 10", gr);
        else n_pass++;
        n_tot++;
        if (oth !== 0) $display("FAIL wr_m0_ack: got %0d want 0", oth);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h8000_0100, 32'h1, 1'b0);
        set_m(1, 1'b1, 1'b0, 32'h8000_0200, 32'h2, 1'b0);
        collect_acks(6, 80);
        n_tot++;
        if (ack_cyc[0] !== 2 + W)
            $display("FAIL rr_first_lat: got %0d want %0d", ack_cyc[0], 2 + W);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_tot++;
            if (ack_own[i] !== i % 2)
                $display("FAIL rr_owner[%0d]: got %0d want %0d", i, ack_own[i], i % 2);
            else n_pass++;
        end
        for (int i = 1; i < 6; i++) begin
            n_tot++;
            if (ack_cyc[i] - ack_cyc[i-1] !== 3 + W)
                $display("FAIL rr_gap[%0d]: got %0d want %0d", i,
                         ack_cyc[i] - ack_cyc[i-1], 3 + W);
            else n_pass++;
        end
        n_tot++;
        if (ack_both !== 0) $display("FAIL rr_dual_ack: got %0d want 0", ack_both);
        else n_pass++;
    endtask

    task automatic test_lock();
        int exp;
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h8000_0300, 32'h3, 1'b0);
        set_m(1, 1'b1, 1'b1, 32'h8000_0400, 32'h4, 1'b1);
        collect_acks(13, 200);
        for (int i = 0; i < 13; i++) begin
            if (i == 0) exp = 0;
            else exp = (((i - 1) % (ML + 2)) < ML + 1) ? 1 : 0;
            n_tot++;
            if (ack_own[i] !== exp)
                $display("FAIL lock_owner[%0d]: got %0d want %0d", i, ack_own[i], exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int seen, ack_at, a_cyc, we_cyc, wd_cyc, oth;
        logic [31:0] rd;
        logic [1:0]  gr;
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h8030_0000, 32'hCAFE_F00D, 1'b0);
        @(posedge cpu_clk);
        #1;
        @(posedge cpu_clk);
        #1;
        n_tot++;
        if ({Bus_addr, Bus_wdata, Bus_we, grant} !== {32'h8030_0000, 32'hCAFE_F00D, 1'b0, 2'b01})
            $display("FAIL rstmid_wait: got %h want %h", {Bus_addr, Bus_wdata, Bus_we, grant},
                     {32'h8030_0000, 32'hCAFE_F00D, 1'b0, 2'b01});
        else n_pass++;
        #2 cpu_rst_n = 1'b0;
        #1;
        n_tot++;
        if ({Bus_addr, Bus_wdata, Bus_we, grant, busy} !== 68'h0)
            $display("FAIL rstmid_async: got %h want 0",
                     {Bus_addr, Bus_wdata, Bus_we, grant, busy});
        else n_pass++;
        set_m(0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge cpu_clk);
        #1 cpu_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge cpu_clk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) seen++;
        end
        n_tot++;
        if (seen !== 0) $display("FAIL rstmid_no_ack: got %0d want 0", seen);
        else n_pass++;
        @(posedge cpu_clk);
        #1;
        set_m(0, 1'b1, 1'b0, 32'h8000_0500, 32'h5, 1'b0);
        set_m(1, 1'b1, 1'b0, 32'h8000_0600, 32'h6, 1'b0);
        collect_acks(1, 20);
        n_tot++;
        if (ack_own[0] !== 0) $display("FAIL rstmid_tie: got %0d want 0", ack_own[0]);
        else n_pass++;
        do_reset();
        drive_one(1, 1'b0, 32'h8000_0700, 32'h7,
                  ack_at, a_cyc, we_cyc, wd_cyc, rd, gr, oth);
        n_tot++;
        if ({ack_at, gr} !== {2 + W, 2'b10})
            $display("FAIL rstmid_m1_alone: got lat %0d grant %b want lat %0d grant 10",
                     ack_at, gr, 2 + W);
        else n_pass++;
    endtask

    task automatic test_random();
        int ph, o, lastg, lcnt, lk;
        int ocnt [2];
        int done [2];
        logic        lpend;
        logic        t_we;
        logic [31:0] t_addr, t_wd;
        logic [69:0] got, expv;
        logic [63:0] erd;
        logic [31:0] ra;
        do_reset();
        ph = 0; o = 0; lastg = 1; lcnt = 0; lpend = 1'b0;
        t_we = 1'b0; t_addr = '0; t_wd = '0;
        ocnt[0] = 0; ocnt[1] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge cpu_clk);
            expv = {(ph > 0) ? ((o == 1) ? 2'b10 : 2'b01) : 2'b00,
                    ph > 0,
                    (ph == 1) ? t_we : 1'b0,
                    (ph == 2 + W) && (o == 0),
                    (ph == 2 + W) && (o == 1),
                    (ph >= 1 && ph <= 1 + W) ? t_addr : 32'h0,
                    (ph >= 1 && ph <= 1 + W) ? t_wd : 32'h0};
            got = {grant, busy, Bus_we, m0_ack, m1_ack, Bus_addr, Bus_wdata};
            n_tot++;
            if (got !== expv) $display("FAIL rnd_cycle[%0d]: got %h want %h", c, got, expv);
            else n_pass++;
            if (!(ph == 2 + W && t_we)) begin
                erd = '0;
                if (ph == 2 + W) begin
                    if (o == 0) erd[63:32] = t_addr ^ 32'h5A5A_A5A5;
                    else erd[31:0] = t_addr ^ 32'h5A5A_A5A5;
                end
                n_tot++;
                if ({m0_rdata, m1_rdata} !== erd)
                    $display("FAIL rnd_rdata[%0d]: got %h want %h", c, {m0_rdata, m1_rdata}, erd);
                else n_pass++;
            end
            done[0] = 0; done[1] = 0;
            if (ph == 2 + W) begin
                lk = (o == 1) ? int'(m1_lock) : int'(m0_lock);
                lastg = o;
                if (lk == 0) lcnt = 0;
                lpend = (lk != 0);
                ocnt[o]++;
                done[o] = 1;
                ph = 0;
            end else if (ph > 0) begin
                ph++;
            end else if (m0_req || m1_req) begin
                if (m0_req && m1_req) begin
                    if (lpend && lcnt < ML) begin
                        o = lastg;
                        lcnt++;
                    end else begin
                        o = 1 - lastg;
                        lcnt = 0;
                    end
                end else begin
                    o = m1_req ? 1 : 0;
                end
                t_we   = (o == 1) ? m1_we : m0_we;
                t_addr = (o == 1) ? m1_addr : m0_addr;
                t_wd   = (o == 1) ? m1_wdata : m0_wdata;
                ph = 1;
            end
            @(posedge cpu_clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (done[m] == 1 || ((m == 0) ? !m0_req : !m1_req)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        ra = $urandom;
                        set_m(m, 1'b1, 1'($urandom_range(0, 1)), ra, $urandom,
                              $urandom_range(0, 2) == 0);
                    end else begin
                        set_m(m, 1'b0, 1'b0, '0, '0, 1'b0);
                    end
                end
            end
        end
        @(negedge cpu_clk);
`ifdef BUS_ARB_PERF_EN
        n_tot++;
        if ({m0_grant_cnt, m1_grant_cnt} !== {32'(ocnt[0]), 32'(ocnt[1])})
            $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d",
                     m0_grant_cnt, m1_grant_cnt, ocnt[0], ocnt[1]);
        else n_pass++;
`endif
        n_tot++;
        if (ocnt[0] + ocnt[1] < 20)
            $display("FAIL rnd_activity: got %0d want >=20", ocnt[0] + ocnt[1]);
        else n_pass++;
        #2 cpu_rst_n = 1'b0;
        #1;
        n_tot++;
        if ({grant, busy, Bus_we, m0_ack, m1_ack} !== 6'b0)
            $display("FAIL rnd_reset: got %b want 0", {grant, busy, Bus_we, m0_ack, m1_ack});
        else n_pass++;
`ifdef BUS_ARB_PERF_EN
        n_tot++;
        if ({m0_grant_cnt, m1_grant_cnt} !== 64'h0)
            $display("FAIL rnd_perf_reset: got %h want 0", {m0_grant_cnt, m1_grant_cnt});
        else n_pass++;
`endif
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
